// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one ALU among NREQ requesters over valid/ready,
// returning each result on a shared response channel tagged with the requester index.

module alu #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o,
    output logic             zero_o,
    output logic             overflow_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum        = '0;
        s_o        = '0;
        c_o        = 1'b0;
        overflow_o = 1'b0;
        case (op_i)
            3'd0: begin
                sum        = {1'b0, x_i} + {1'b0, y_i};
                s_o        = sum[WIDTH-1:0];
                c_o        = sum[WIDTH];
                overflow_o = (x_i[WIDTH-1] == y_i[WIDTH-1]) && (s_o[WIDTH-1] != x_i[WIDTH-1]);
            end
            3'd1: begin
                // Carry is the carry-out of x + ~y + 1, i.e. 1 means no borrow.
                sum        = {1'b0, x_i} + {1'b0, ~y_i} + (WIDTH+1)'(1);
                s_o        = sum[WIDTH-1:0];
                c_o        = sum[WIDTH];
                overflow_o = (x_i[WIDTH-1] != y_i[WIDTH-1]) && (s_o[WIDTH-1] != x_i[WIDTH-1]);
            end
            3'd2:    s_o = ~x_i;
            3'd3:    s_o = x_i & y_i;
            3'd4:    s_o = x_i | y_i;
            3'd5:    s_o = x_i ^ y_i;
            3'd6:    s_o = WIDTH'($signed(x_i) < $signed(y_i));
            default: s_o = '0;
        endcase
        zero_o = (s_o == '0);
    end

endmodule

module alu_arbiter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_x,
    input  logic [WIDTH*NREQ-1:0] req_y,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_s,
    output logic                  rsp_c,
    output logic                  rsp_zero,
    output logic                  rsp_overflow,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d, zero_q, zero_d, ovf_q, ovf_d;

    logic             found;
    logic [IDW-1:0]   grant_idx;
    int unsigned      idx;

    logic [WIDTH-1:0] alu_s;
    logic             alu_c, alu_zero, alu_ovf;

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op_i       (op_q),
        .x_i        (x_q),
        .y_i        (y_q),
        .s_o        (alu_s),
        .c_o        (alu_c),
        .zero_o     (alu_zero),
        .overflow_o (alu_ovf)
    );

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        op_d      = op_q;
        x_d       = x_q;
        y_d       = y_q;
        s_d       = s_q;
        c_d       = c_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        req_ready = '0;
        case (state_q)
            StIdle: begin
                if (found) begin
                    req_ready = NREQ'(1) << grant_idx;
                    op_d      = req_op[3*grant_idx +: 3];
                    x_d       = req_x[WIDTH*grant_idx +: WIDTH];
                    y_d       = req_y[WIDTH*grant_idx +: WIDTH];
                    id_d      = grant_idx;
                    ptr_d     = IDW'((32'(grant_idx) + 32'd1) % NREQ);
                    state_d   = StExec;
                end
            end
            StExec: begin
                s_d     = alu_s;
                c_d     = alu_c;
                zero_d  = alu_zero;
                ovf_d   = alu_ovf;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            id_q    <= '0;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s_q     <= s_d;
            c_q     <= c_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rsp_valid    = (state_q == StResp);
    assign busy         = (state_q != StIdle);
    assign rsp_id       = id_q;
    assign rsp_s        = s_q;
    assign rsp_c        = c_q;
    assign rsp_zero     = zero_q;
    assign rsp_overflow = ovf_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: an abstract transaction model checked every cycle,
// plus literal expectations from hand-worked ALU results and grant orders.

module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [11:0] req_op = '0;
    logic [15:0] req_x = '0;
    logic [15:0] req_y = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_s;
    logic        rsp_c, rsp_zero, rsp_overflow, busy;

    int n_checks = 0;
    int n_errors = 0;
    int hs_cnt   = 0;
    int hs0      = 0;
    bit chk_en   = 1'b0;

    alu_arbiter #(
        .WIDTH (4),
        .NREQ  (4),
        .IDW   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_x        (req_x),
        .req_y        (req_y),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_s        (rsp_s),
        .rsp_c        (rsp_c),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU on plain integers: returns {s[3:0], c, zero, overflow}.
    function automatic logic [6:0] alu_ref(input int op, input int x, input int y);
        int sx, sy, r, sr;
        logic [3:0] xv, yv, s;
        logic c, v;
        sx = (x >= 8) ? x - 16 : x;
        sy = (y >= 8) ? y - 16 : y;
        xv = x[3:0];
        yv = y[3:0];
        c = 1'b0;
        v = 1'b0;
        s = 4'd0;
        case (op)
            0: begin
                r = x + y; s = r[3:0]; c = (r >= 16);
                sr = sx + sy; v = (sr > 7) || (sr < -8);
            end
            1: begin
                r = x + (15 - y) + 1; s = r[3:0]; c = (r >= 16);
                sr = sx - sy; v = (sr > 7) || (sr < -8);
            end
            2: s = 4'hF - xv;
            3: s = xv & yv;
            4: s = xv | yv;
            5: s = xv ^ yv;
            6: s = (sx < sy) ? 4'd1 : 4'd0;
            default: s = 4'd0;
        endcase
        return {s, c, (s == 4'd0), v};
    endfunction

    function automatic int pick(input logic [3:0] v, input int p);
        for (int i = 0; i < 4; i++) begin
            if (v[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    // Transaction model: 0 = waiting for a request, 1 = computing, 2 = response offered.
    int         m_phase = 0;
    int         m_ptr = 0;
    int         m_id = 0;
    logic [6:0] m_res = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_ptr   <= 0;
        end else if (m_phase == 0) begin
            if (pick(req_valid, m_ptr) >= 0) begin
                m_phase <= 1;
                m_id    <= pick(req_valid, m_ptr);
                m_ptr   <= (pick(req_valid, m_ptr) + 1) % 4;
                m_res   <= alu_ref(int'(req_op[3*pick(req_valid, m_ptr) +: 3]),
                                   int'(req_x[4*pick(req_valid, m_ptr) +: 4]),
                                   int'(req_y[4*pick(req_valid, m_ptr) +: 4]));
            end
        end else if (m_phase == 1) begin
            m_phase <= 2;
        end else if (rsp_ready) begin
            m_phase <= 0;
        end
    end

    always @(posedge clk) begin
        if (!rst && rsp_valid && rsp_ready) hs_cnt <= hs_cnt + 1;
    end

    function automatic logic [3:0] exp_ready();
        int g;
        g = pick(req_valid, m_ptr);
        if (m_phase != 0 || g < 0) return 4'b0000;
        return 4'b0001 << g;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model req_ready", req_ready, exp_ready());
            chk("model rsp_valid", rsp_valid, m_phase == 2);
            chk("model busy", busy, m_phase != 0);
            if (m_phase == 2) begin
                chk("model rsp_id", rsp_id, m_id);
                chk("model rsp_flags", {rsp_s, rsp_c, rsp_zero, rsp_overflow}, m_res);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [3:0] x,
                           input logic [3:0] y);
        req_valid[i]    = 1'b1;
        req_op[3*i +: 3] = op;
        req_x[4*i +: 4]  = x;
        req_y[4*i +: 4]  = y;
    endtask

    task automatic chk_rsp(input string name, input logic [1:0] id, input logic [3:0] s,
                           input logic c, input logic z, input logic v);
        chk({name, " valid"}, rsp_valid, 1'b1);
        chk({name, " id"}, rsp_id, id);
        chk({name, " s"}, rsp_s, s);
        chk({name, " c/zero/ovf"}, {rsp_c, rsp_zero, rsp_overflow}, {c, z, v});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset req_ready", req_ready, 4'b0000);
        chk("reset rsp_valid/busy", {rsp_valid, busy}, 2'b00);
        chk("reset rsp_id/s", {rsp_id, rsp_s}, 6'd0);
        chk("reset c/zero/ovf", {rsp_c, rsp_zero, rsp_overflow}, 3'b000);

        // Single request: 0111 + 0001
        set_req(2, 3'd0, 4'b0111, 4'b0001);
        #1 chk("single ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        chk("single ready drop", req_ready, 4'b0000);
        tick();
        chk_rsp("single", 2'd2, 4'b1000, 1'b0, 1'b0, 1'b1);
        tick();

        // All four valid from reset: 0011 + 1101
        rst = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 3'd0, 4'b0011, 4'b1101);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("all4 grant", req_ready, 4'b0001 << k);
            tick();
            req_valid[k] = 1'b0;
            tick();
            chk_rsp("all4", 2'(k), 4'b0000, 1'b1, 1'b1, 1'b0);
            tick();
        end

        // Fairness: grant 2, then 1 and 3 waiting -> 3, 1, then ptr = 2
        set_req(2, 3'd2, 4'b0101, 4'b0000);
        #1 chk("fair grant2", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        set_req(1, 3'd4, 4'b0001, 4'b0010);
        set_req(3, 3'd5, 4'b1111, 4'b0101);
        tick();
        chk_rsp("fair not", 2'd2, 4'b1010, 1'b0, 1'b0, 1'b0);
        tick();
        chk("fair grant3", req_ready, 4'b1000);
        tick();
        req_valid[3] = 1'b0;
        tick();
        chk_rsp("fair xor", 2'd3, 4'b1010, 1'b0, 1'b0, 1'b0);
        tick();
        chk("fair grant1", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        tick();
        chk_rsp("fair or", 2'd1, 4'b0011, 1'b0, 1'b0, 1'b0);
        tick();
        req_valid = 4'b1111;
        #1 chk("fair ptr2", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        tick();
        tick();

        // Backpressure: 1000 - 0001 with rsp_ready low, requester 1 waiting behind it
        set_req(0, 3'd1, 4'b1000, 4'b0001);
        #1 chk("bp grant0", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        set_req(1, 3'd6, 4'b1000, 4'b0001);
        rsp_ready = 1'b0;
        tick();
        hs0 = hs_cnt;
        for (int k = 0; k < 5; k++) begin
            chk_rsp("bp hold", 2'd0, 4'b0111, 1'b1, 1'b0, 1'b1);
            chk("bp no grant", req_ready, 4'b0000);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp one accept", hs_cnt, hs0 + 1);
        chk("bp next grant1", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        tick();
        chk_rsp("bp slt", 2'd1, 4'b0001, 1'b0, 1'b0, 1'b0);
        chk("bp no extra accept", hs_cnt, hs0 + 1);
        tick();

        // Operand isolation: 1100 & 0011, x changed after grant
        set_req(1, 3'd3, 4'b1100, 4'b0011);
        #1 chk("iso grant1", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        req_x[4 +: 4] = 4'b1111;
        tick();
        chk_rsp("iso and", 2'd1, 4'b0000, 1'b0, 1'b1, 1'b0);
        tick();

        // Reset during EXEC discards the operation and clears ptr
        set_req(1, 3'd0, 4'b0001, 4'b0001);
        #1 chk("rst grant1", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        chk("rst in exec", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst busy/valid", {busy, rsp_valid}, 2'b00);
        hs0 = hs_cnt;
        repeat (4) tick();
        chk("rst no response", hs_cnt, hs0);
        chk("rst rsp_valid low", rsp_valid, 1'b0);
        set_req(0, 3'd0, 4'b0010, 4'b0011);
        set_req(2, 3'd0, 4'b0100, 4'b0100);
        #1 chk("rst ptr0 grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        tick();
        chk_rsp("rst after", 2'd0, 4'b0101, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
